// File: rtl/ad9361_pkg.sv
// Shared AD9361 SPI definitions: frame layout, FSM state codes and a frame builder.
package ad9361_pkg;

  localparam int unsigned FRAME_W  = 24;
  localparam int unsigned WRB_BIT  = 23;
  localparam int unsigned NB_MSB   = 22;
  localparam int unsigned NB_LSB   = 20;
  localparam logic [2:0]  NB_ONE   = 3'b000;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned ADDR_MSB = 17;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  // FSM state encoding
  typedef logic [2:0] spi_state_t;
  localparam spi_state_t ST_IDLE  = 3'd0;
  localparam spi_state_t ST_SETUP = 3'd1;
  localparam spi_state_t ST_SHIFT = 3'd2;
  localparam spi_state_t ST_HOLD  = 3'd3;
  localparam spi_state_t ST_GAP   = 3'd4;

  // Assemble a single-byte instruction frame; reads carry a zero data byte
  function automatic logic [FRAME_W-1:0] build_frame(input logic              wr,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f                      = '0;
    f[WRB_BIT]             = wr;
    f[NB_MSB:NB_LSB]       = NB_ONE;
    f[ADDR_MSB:ADDR_LSB]   = addr;
    f[DATA_MSB:DATA_LSB]   = wr ? data : '0;
    return f;
  endfunction

endpackage

// File: rtl/ad9361_spi_master.sv
// Single-transaction SPI master for AD9361 single-byte register writes and reads.
module ad9361_spi_master
  import ad9361_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_wr_req,
  input  logic [9:0] spi_wr_addr,
  input  logic [7:0] spi_wr_data,
  output logic       spi_wr_end,
  input  logic       spi_rd_req,
  input  logic [9:0] spi_rd_addr,
  output logic [7:0] spi_rd_data,
  output logic       spi_rd_end,
  output logic       busy,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int unsigned BIT_PERIOD = 2 * CLK_DIV;
  localparam int unsigned MAX_A      = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned MAX_B      = (IDLE_GAP > BIT_PERIOD) ? IDLE_GAP : BIT_PERIOD;
  localparam int unsigned CNT_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX);
  localparam int unsigned BIT_W      = $clog2(FRAME_W);

  spi_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               is_wr_q, is_wr_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               wr_end_q, wr_end_d;
  logic               rd_end_q, rd_end_d;
  logic               busy_q, busy_d;
  logic               csn_q, csn_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;

  // Next-state logic; pin values are derived from the next state so they register cleanly
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    is_wr_d   = is_wr_q;
    rd_data_d = rd_data_q;
    wr_end_d  = 1'b0;
    rd_end_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (spi_wr_req) begin
          sr_d    = build_frame(1'b1, spi_wr_addr, spi_wr_data);
          is_wr_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end else if (spi_rd_req) begin
          sr_d    = build_frame(1'b0, spi_rd_addr, 8'h00);
          is_wr_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        // Last cycle of the high phase: capture MISO and advance the outgoing bit
        if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
          sr_d  = {sr_q[FRAME_W-2:0], spi_miso};
          cnt_d = '0;
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (is_wr_q) begin
            wr_end_d = 1'b1;
          end else begin
            rd_end_d  = 1'b1;
            rd_data_d = sr_q[7:0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    csn_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
    sclk_d = (state_d == ST_SHIFT) && (cnt_d >= CNT_W'(CLK_DIV));
    mosi_d = ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) ? sr_d[FRAME_W-1] : 1'b0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      is_wr_q   <= 1'b0;
      rd_data_q <= 8'h00;
      wr_end_q  <= 1'b0;
      rd_end_q  <= 1'b0;
      busy_q    <= 1'b0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      is_wr_q   <= is_wr_d;
      rd_data_q <= rd_data_d;
      wr_end_q  <= wr_end_d;
      rd_end_q  <= rd_end_d;
      busy_q    <= busy_d;
      csn_q     <= csn_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign spi_wr_end  = wr_end_q;
  assign spi_rd_end  = rd_end_q;
  assign spi_rd_data = rd_data_q;
  assign busy        = busy_q;
  assign spi_csn     = csn_q;
  assign spi_clk     = sclk_q;
  assign spi_mosi    = mosi_q;

endmodule
